crc_stream_check: RTL



---
 rtl/crc_pkg.sv | 11 +
 rtl/crc.sv | 24 ++
 rtl/crc_stream_check.sv | 99 +++++++++
 3 files changed

// File: rtl/crc_pkg.sv
// crc_pkg: shared CRC-32 polynomial type and constant.
// Contents:
//   crc32_poly_t  32-bit polynomial word (x^32 term implicit)
//   CRC32_POLY    IEEE 802.3 generator polynomial, normal form
package crc_pkg;

    typedef logic [31:0] crc32_poly_t;

    localparam crc32_poly_t CRC32_POLY = 32'h04c11db7;

endpackage

// File: rtl/crc.sv
// crc: combinational CRC of one word, rem = (data(x) * x^POLY_SIZE) mod POLY.
// Ports:
//   data  in   DATA_WIDTH  word to reduce; bit i is the coefficient of x^i
//   rem   out  POLY_SIZE   remainder; zero initial value, no reflection, no final XOR
module crc
    import crc_pkg::*;
#(
    parameter int                    POLY_SIZE  = 32,
    parameter logic [POLY_SIZE-1:0]  POLY       = CRC32_POLY,
    parameter int                    DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] data,
    output logic [POLY_SIZE-1:0]  rem
);

    // MSB-first LFSR from zero; feeding message bits into the feedback tap
    // multiplies the message by x^POLY_SIZE before the reduction.
    always_comb begin
        rem = '0;
        for (int i = DATA_WIDTH - 1; i >= 0; i--)
            rem = (rem << 1) ^ ((data[i] ^ rem[POLY_SIZE-1]) ? POLY : '0);
    end

endmodule

// File: rtl/crc_stream_check.sv
// crc_stream_check: checks a CRC trailer on a valid/ready frame stream and forwards the payload.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   s_valid    in   input beat valid
//   s_ready    out  input beat accepted when s_valid && s_ready
//   s_data     in   input word; on the trailer beat, s_data[POLY_SIZE-1:0] is the CRC
//   s_last     in   marks the trailer beat
//   m_valid    out  payload beat valid
//   m_ready    in   downstream ready
//   m_data     out  payload word
//   m_last     out  final payload beat of the frame
//   res_valid  out  one-cycle pulse per frame, no backpressure
//   res_ok     out  received CRC matched; qualified by res_valid
module crc_stream_check
    import crc_pkg::*;
#(
    parameter int                    POLY_SIZE  = 32,
    parameter logic [POLY_SIZE-1:0]  POLY       = CRC32_POLY,
    parameter int                    DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  res_valid,
    output logic                  res_ok
);

    if (DATA_WIDTH < POLY_SIZE) begin : g_width_check
        $error("crc_stream_check: DATA_WIDTH must be >= POLY_SIZE");
    end

    logic [POLY_SIZE-1:0]  acc;
    logic [DATA_WIDTH-1:0] acc_ext;
    logic [DATA_WIDTH-1:0] crc_in;
    logic [POLY_SIZE-1:0]  crc_out;
    logic [DATA_WIDTH-1:0] h_data;
    logic                  h_valid;
    logic                  accept;

    assign s_ready = !m_valid || m_ready;
    assign accept  = s_valid && s_ready;

    // The running remainder is folded into the top of the next word.
    assign acc_ext = DATA_WIDTH'(acc);
    assign crc_in  = s_data ^ (acc_ext << (DATA_WIDTH - POLY_SIZE));

    crc #(
        .POLY_SIZE  (POLY_SIZE),
        .POLY       (POLY),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_crc (
        .data (crc_in),
        .rem  (crc_out)
    );

    // H delays the payload by one beat so the last payload beat is known
    // (and tagged) when the trailer arrives; the trailer itself is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            h_data    <= '0;
            h_valid   <= 1'b0;
            m_data    <= '0;
            m_valid   <= 1'b0;
            m_last    <= 1'b0;
            res_valid <= 1'b0;
            res_ok    <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            if (m_valid && m_ready)
                m_valid <= 1'b0;
            if (accept) begin
                if (h_valid) begin
                    m_data  <= h_data;
                    m_last  <= s_last;
                    m_valid <= 1'b1;
                end
                if (s_last) begin
                    acc       <= '0;
                    h_valid   <= 1'b0;
                    res_valid <= 1'b1;
                    res_ok    <= (s_data[POLY_SIZE-1:0] == acc);
                end else begin
                    acc     <= crc_out;
                    h_data  <= s_data;
                    h_valid <= 1'b1;
                end
            end
        end
    end

endmodule
